// File: rtl/fir_ctrl_pkg.sv
// fir_ctrl_pkg: tap-load FSM states and defaults; FIR_TAP_SYMMETRIC_EN selects a half-depth mirrored shadow bank
package fir_ctrl_pkg;
  localparam int TAP_NUM_DEF     = 90;
  localparam int TAP_NUM_MAX_DEF = 899;
  localparam int ADDR_WIDTH_DEF  = 10;
  typedef enum logic [1:0] {IDLE, STALL, LOAD, FLUSH} state_t;
  function automatic int shadow_depth(input int tap_num);
`ifdef FIR_TAP_SYMMETRIC_EN
    return tap_num / 2;
`else
    return tap_num;
`endif
  endfunction
endpackage

// File: rtl/fir_tap_shadow_ram.sv
// fir_tap_shadow_ram: register-array shadow tap bank, 1 write / 1 registered read; FIR_TAP_SYMMETRIC_EN mirrors upper reads
module fir_tap_shadow_ram import fir_ctrl_pkg::*; #(
  parameter int TAP_NUM    = TAP_NUM_DEF,
  parameter int TAP_WIDTH  = 32,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [TAP_WIDTH-1:0]  wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [TAP_WIDTH-1:0]  rdata
);
  localparam int DEPTH = shadow_depth(TAP_NUM);
  localparam int AW    = $clog2(DEPTH);
  logic [TAP_WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_WIDTH-1:0] ridx;
`ifdef FIR_TAP_SYMMETRIC_EN
  assign ridx = (raddr >= ADDR_WIDTH'(DEPTH)) ? ADDR_WIDTH'(TAP_NUM - 1) - raddr : raddr;
`else
  assign ridx = raddr;
`endif
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rdata <= '0;
    end else begin
      if (we && waddr < ADDR_WIDTH'(DEPTH)) mem[waddr[AW-1:0]] <= wdata;
      if (re && ridx < ADDR_WIDTH'(DEPTH)) rdata <= mem[ridx[AW-1:0]];
    end
endmodule

// File: rtl/fir_tap_load_ctrl.sv
// fir_tap_load_ctrl: commits shadow taps into the FIR via stall, load and output-blanking flush; FIR_TAP_SYMMETRIC_EN halves the bank
module fir_tap_load_ctrl import fir_ctrl_pkg::*; #(
  parameter int TAP_NUM      = TAP_NUM_DEF,
  parameter int TAP_WIDTH    = 32,
  parameter int ADDR_WIDTH   = ADDR_WIDTH_DEF,
  parameter int TAP_NUM_MAX  = TAP_NUM_MAX_DEF,
  parameter int STALL_CYCLES = 4,
  parameter int FLUSH_LEN    = 900
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  cfg_wr_vld_i,
  input  logic [ADDR_WIDTH-1:0] cfg_wr_addr_i,
  input  logic [TAP_WIDTH-1:0]  cfg_wr_data_i,
  input  logic [ADDR_WIDTH-1:0] cfg_tap_num_i,
  input  logic                  cfg_commit_i,
  output logic                  cfg_busy_o,
  output logic                  cfg_done_o,
  output logic                  cfg_err_o,
  input  logic                  ds_tready_i,
  output logic                  fir_m_tready_o,
  input  logic                  fir_s_hs_i,
  output logic                  fir_tap_vld_o,
  output logic [ADDR_WIDTH-1:0] fir_tap_addr_o,
  output logic [TAP_WIDTH-1:0]  fir_tap_data_o,
  output logic [ADDR_WIDTH-1:0] fir_tap_num_o,
  output logic                  out_blank_o
);
  localparam int DEPTH = shadow_depth(TAP_NUM);
  localparam int CW    = $clog2(FLUSH_LEN > TAP_NUM ? FLUSH_LEN : TAP_NUM) + 1;
  state_t                state, state_d;
  logic [CW-1:0]         cnt, cnt_d;
  logic [ADDR_WIDTH-1:0] num, num_d, tap_num_d, tap_addr_d;
  logic                  done_d, err_d, tap_vld_d, idle, addr_ok, num_big, wr_en, rd_en;
  assign idle           = state == IDLE;
  assign addr_ok        = cfg_wr_addr_i < ADDR_WIDTH'(DEPTH);
  assign num_big        = cfg_tap_num_i > ADDR_WIDTH'(TAP_NUM_MAX);
  assign wr_en          = idle && cfg_wr_vld_i && addr_ok;
  assign rd_en          = state == LOAD && cnt < CW'(TAP_NUM);
  assign cfg_busy_o     = !idle;
  assign out_blank_o    = state == FLUSH;
  assign fir_m_tready_o = (idle || state == FLUSH) && ds_tready_i;
  always_comb begin
    state_d    = state;
    cnt_d      = '0;
    num_d      = num;
    tap_num_d  = fir_tap_num_o;
    done_d     = 1'b0;
    err_d      = idle ? (cfg_wr_vld_i && !addr_ok) || (cfg_commit_i && num_big) : cfg_wr_vld_i || cfg_commit_i;
    tap_vld_d  = rd_en;
    tap_addr_d = rd_en ? ADDR_WIDTH'(cnt) : fir_tap_addr_o;
    case (state)
      IDLE: if (cfg_commit_i) begin
        state_d = STALL;
        num_d   = num_big ? ADDR_WIDTH'(TAP_NUM_MAX) : cfg_tap_num_i;
      end
      STALL: begin
        cnt_d = cnt + CW'(1);
        if (cnt == CW'(STALL_CYCLES - 1)) begin
          state_d = LOAD;
          cnt_d   = '0;
        end
      end
      // one extra cycle lets the registered read of the last tap leave before the count switches
      LOAD: begin
        cnt_d = cnt + CW'(1);
        if (cnt == CW'(TAP_NUM)) begin
          state_d   = FLUSH;
          cnt_d     = '0;
          tap_num_d = num;
        end
      end
      default: begin
        cnt_d = cnt + CW'(fir_s_hs_i);
        if (fir_s_hs_i && cnt == CW'(FLUSH_LEN - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end
      end
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      state          <= IDLE;
      cnt            <= '0;
      num            <= '0;
      fir_tap_num_o  <= '0;
      fir_tap_vld_o  <= 1'b0;
      fir_tap_addr_o <= '0;
      cfg_done_o     <= 1'b0;
      cfg_err_o      <= 1'b0;
    end else begin
      state          <= state_d;
      cnt            <= cnt_d;
      num            <= num_d;
      fir_tap_num_o  <= tap_num_d;
      fir_tap_vld_o  <= tap_vld_d;
      fir_tap_addr_o <= tap_addr_d;
      cfg_done_o     <= done_d;
      cfg_err_o      <= err_d;
    end
  fir_tap_shadow_ram #(.TAP_NUM(TAP_NUM), .TAP_WIDTH(TAP_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_shadow (
    .clk_i  (clk_i),
    .rst_n_i(rst_n_i),
    .we     (wr_en),
    .waddr  (cfg_wr_addr_i),
    .wdata  (cfg_wr_data_i),
    .re     (rd_en),
    .raddr  (ADDR_WIDTH'(cnt)),
    .rdata  (fir_tap_data_o)
  );
endmodule

// File: tb/tb_fir_tap_load_ctrl.sv
// tb_fir_tap_load_ctrl: randomized bench against a commit-timeline model; FIR_TAP_SYMMETRIC_EN selects the mirrored-bank checks
module tb_fir_tap_load_ctrl;
  localparam int TAP_NUM = 90, TAP_NUM_MAX = 899, STALL = 4, FLUSH_LEN = 900;
`ifdef FIR_TAP_SYMMETRIC_EN
  localparam bit SYM = 1'b1;
`else
  localparam bit SYM = 1'b0;
`endif
  localparam int DEPTH   = SYM ? TAP_NUM / 2 : TAP_NUM;
  localparam int FIRST_T = STALL + 1;
  localparam int FLUSH_T = STALL + TAP_NUM + 1;
  logic        clk_i = 1'b0, rst_n_i = 1'b0, cfg_wr_vld_i = 1'b0, cfg_commit_i = 1'b0;
  logic        ds_tready_i = 1'b0, fir_s_hs_i = 1'b0;
  logic [9:0]  cfg_wr_addr_i = '0, cfg_tap_num_i = '0, fir_tap_addr_o, fir_tap_num_o;
  logic [31:0] cfg_wr_data_i = '0, fir_tap_data_o;
  logic        cfg_busy_o, cfg_done_o, cfg_err_o, fir_m_tready_o, fir_tap_vld_o, out_blank_o;
  int          tests = 0, fails = 0;
  bit          hs_hold = 1'b0;
  fir_tap_load_ctrl dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .cfg_wr_vld_i(cfg_wr_vld_i), .cfg_wr_addr_i(cfg_wr_addr_i), .cfg_wr_data_i(cfg_wr_data_i),
    .cfg_tap_num_i(cfg_tap_num_i), .cfg_commit_i(cfg_commit_i),
    .cfg_busy_o(cfg_busy_o), .cfg_done_o(cfg_done_o), .cfg_err_o(cfg_err_o),
    .ds_tready_i(ds_tready_i), .fir_m_tready_o(fir_m_tready_o), .fir_s_hs_i(fir_s_hs_i),
    .fir_tap_vld_o(fir_tap_vld_o), .fir_tap_addr_o(fir_tap_addr_o), .fir_tap_data_o(fir_tap_data_o),
    .fir_tap_num_o(fir_tap_num_o), .out_blank_o(out_blank_o)
  );
  always #5 clk_i = ~clk_i;
  function automatic void chk(input string n, input logic [31:0] a, input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endfunction
  // model: a commit starts a timeline t (cycles since acceptance) that ends on the FLUSH_LEN-th handshake
  logic [31:0] sh [TAP_NUM];
  bit          m_active, m_done, m_err;
  int          m_t, m_hs;
  logic [9:0]  m_num, m_lat;
  function automatic logic [31:0] exp_tap(input int k);
    return (SYM && k >= DEPTH) ? sh[TAP_NUM-1-k] : sh[k];
  endfunction
  always @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      m_active = 0; m_done = 0; m_err = 0; m_t = 0; m_hs = 0; m_num = '0; m_lat = '0;
      for (int i = 0; i < TAP_NUM; i++) sh[i] = '0;
    end else begin
      m_done = 0;
      m_err  = 0;
      if (!m_active) begin
        if (cfg_wr_vld_i) begin
          if (int'(cfg_wr_addr_i) < DEPTH) sh[cfg_wr_addr_i] = cfg_wr_data_i;
          else m_err = 1;
        end
        if (cfg_commit_i) begin
          m_active = 1; m_t = 0; m_hs = 0;
          if (int'(cfg_tap_num_i) > TAP_NUM_MAX) begin m_lat = 10'(TAP_NUM_MAX); m_err = 1; end
          else m_lat = cfg_tap_num_i;
        end
      end else begin
        if (cfg_wr_vld_i || cfg_commit_i) m_err = 1;
        if (m_t >= FLUSH_T && fir_s_hs_i) m_hs++;
        if (m_hs == FLUSH_LEN) begin m_active = 0; m_done = 1; end
        else begin
          m_t++;
          if (m_t == FLUSH_T) m_num = m_lat;
        end
      end
    end
  end
  always @(negedge clk_i) begin : cmp
    bit fl, vl;
    fl = m_active && m_t >= FLUSH_T;
    vl = m_active && m_t >= FIRST_T && m_t < FLUSH_T;
    if (rst_n_i) begin
      chk("busy", 32'(cfg_busy_o), 32'(m_active));
      chk("done", 32'(cfg_done_o), 32'(m_done));
      chk("err", 32'(cfg_err_o), 32'(m_err));
      chk("blank", 32'(out_blank_o), 32'(fl));
      chk("tready", 32'(fir_m_tready_o), 32'((!m_active || fl) && ds_tready_i));
      chk("tap_vld", 32'(fir_tap_vld_o), 32'(vl));
      chk("tap_num", 32'(fir_tap_num_o), 32'(m_num));
      if (vl) begin
        chk("tap_addr", 32'(fir_tap_addr_o), 32'(m_t - FIRST_T));
        chk("tap_data", fir_tap_data_o, exp_tap(m_t - FIRST_T));
      end
    end
  end
  int          vld_cnt = 0, hs_blank = 0, first_addr = -1;
  bit          seen_first = 0;
  logic [31:0] cap [TAP_NUM];
  always @(negedge clk_i) begin
    if (cfg_commit_i && !cfg_busy_o) begin vld_cnt = 0; hs_blank = 0; seen_first = 0; end
    if (fir_tap_vld_o) begin
      vld_cnt++;
      if (int'(fir_tap_addr_o) < TAP_NUM) cap[fir_tap_addr_o] = fir_tap_data_o;
      if (!seen_first) begin first_addr = int'(fir_tap_addr_o); seen_first = 1; end
    end
    if (out_blank_o && fir_s_hs_i) hs_blank++;
  end
  always @(posedge clk_i) begin
    #1;
    ds_tready_i = $urandom_range(0, 3) != 0;
    fir_s_hs_i  = !hs_hold && $urandom_range(0, 3) != 0;
  end
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask
  task automatic wr(input int a, input int d);
    cfg_wr_vld_i = 1; cfg_wr_addr_i = 10'(a); cfg_wr_data_i = 32'(d);
    tick();
    cfg_wr_vld_i = 0;
  endtask
  task automatic commit(input int n);
    cfg_commit_i = 1; cfg_tap_num_i = 10'(n);
    tick();
    cfg_commit_i = 0;
  endtask
  task automatic wait_done();
    bit ok = 0;
    for (int i = 0; i < 5000 && !ok; i++) begin @(negedge clk_i); ok = cfg_done_o; end
    chk("done_timeout", 32'(ok), 32'd1);
    tick();
  endtask
  task automatic wait_tap(input int a);
    bit ok = 0;
    for (int i = 0; i < 300 && !ok; i++) begin @(negedge clk_i); ok = fir_tap_vld_o && fir_tap_addr_o == 10'(a); end
    chk("tap_wait", 32'(ok), 32'd1);
  endtask
  initial begin
    repeat (3) @(posedge clk_i);
    #1 rst_n_i = 1;
    tick();
    chk("rst_busy", 32'(cfg_busy_o), 0);
    chk("rst_num", 32'(fir_tap_num_o), 0);
    chk("rst_data", fir_tap_data_o, 0);
    // taps 1..90 (mirrored build: 0..44), full-length sequence
    for (int i = 0; i < DEPTH; i++) wr(i, SYM ? i : i + 1);
    commit(89);
    wait_done();
    chk("t1_cnt", 32'(vld_cnt), 90);
    chk("t1_hs", 32'(hs_blank), 900);
    chk("t1_d0", cap[0], SYM ? 0 : 1);
    chk("t1_d45", cap[45], SYM ? 44 : 46);
    chk("t1_d89", cap[89], SYM ? 0 : 90);
    chk("t1_num", 32'(fir_tap_num_o), 89);
    commit(1000);
    chk("t2_err", 32'(cfg_err_o), 1);
    wait_done();
    chk("t2_num", 32'(fir_tap_num_o), 899);
    wr(95, 32'h5555);
    chk("t3_err", 32'(cfg_err_o), 1);
    commit(10);
    wait_tap(20);
    commit(500);
    chk("t3_err_load", 32'(cfg_err_o), 1);
    wait_done();
    chk("t3_num", 32'(fir_tap_num_o), 10);
    chk("t3_cnt", 32'(vld_cnt), 90);
    commit(5);
    begin
      bit ok = 0;
      for (int i = 0; i < 300 && !ok; i++) begin @(negedge clk_i); ok = out_blank_o; end
      chk("t4_blank_wait", 32'(ok), 1);
    end
    hs_hold = 1;
    repeat (50) tick();
    chk("t4_busy", 32'(cfg_busy_o), 1);
    chk("t4_blank", 32'(out_blank_o), 1);
    hs_hold = 0;
    wait_done();
    chk("t4_hs", 32'(hs_blank), 900);
    commit(7);
    wait_tap(40);
    rst_n_i = 0;
    #1;
    chk("t5_busy", 32'(cfg_busy_o), 0);
    chk("t5_vld", 32'(fir_tap_vld_o), 0);
    chk("t5_addr", 32'(fir_tap_addr_o), 0);
    chk("t5_data", fir_tap_data_o, 0);
    chk("t5_num", 32'(fir_tap_num_o), 0);
    chk("t5_blank", 32'(out_blank_o), 0);
    chk("t5_tready", 32'(fir_m_tready_o), 32'(ds_tready_i));
    tick();
    rst_n_i = 1;
    tick();
    for (int i = 0; i < DEPTH; i++) wr(i, int'($urandom));
    commit(20);
    wait_done();
    chk("t5_first", 32'(first_addr), 0);
    chk("t5_cnt", 32'(vld_cnt), 90);
    cfg_wr_vld_i = 1; cfg_wr_addr_i = '0; cfg_wr_data_i = 32'hABCD;
    cfg_commit_i = 1; cfg_tap_num_i = 10'd3;
    tick();
    cfg_wr_vld_i = 0; cfg_commit_i = 0;
    wait_done();
    chk("wc_d0", cap[0], 32'hABCD);
    repeat (3) begin
      repeat ($urandom_range(5, 30)) begin
        int a;
        a = int'($urandom_range(0, DEPTH + 10));
        wr(a, int'($urandom));
      end
      commit(int'($urandom_range(0, 1100)));
      wait_done();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #1500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
